// File: rtl/framer_pkg.sv
// Shared types and constants for the signal_send framer: FSM state
// encoding, default header bytes and the per-sample byte index helpers.
package framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_SEQ  = 3'd3,
        ST_DATA = 3'd4,
        ST_CSUM = 3'd5
    } frame_state_t;

    localparam logic [7:0] DEFAULT_HDR0 = 8'hA5;
    localparam logic [7:0] DEFAULT_HDR1 = 8'h5A;

    // Four bytes per 32-bit sample, so a 2-bit index walks through them.
    localparam int BYTE_IDX_W = 2;
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = 2'd3;

    // Big-endian byte selection: index 0 is the most significant byte.
    function automatic logic [7:0] sample_byte(input logic [31:0] sample,
                                               input logic [BYTE_IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = sample[31:24];
            2'd1:    b = sample[23:16];
            2'd2:    b = sample[15:8];
            default: b = sample[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/send_fifo.sv
// Synchronous sample FIFO with first-word-fall-through read: dout shows the
// oldest entry whenever the FIFO is not empty. Occupancy is a registered
// counter; full/empty are decoded from it, so a same-cycle pop never makes
// room for a push.
module send_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign level   = count;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/signal_send_framer.sv
// Buffers the modulated 32-bit sample stream and emits fixed-length byte
// frames (HDR0, HDR1, SEQ, N big-endian samples, XOR checksum) over a
// ready/valid byte interface. The upstream has no backpressure, so samples
// arriving while the FIFO is full are dropped and flagged by a sticky bit.
module signal_send_framer
    import framer_pkg::*;
#(
    parameter int         SAMPLES_PER_FRAME = 8,
    parameter int         FIFO_DEPTH        = 16,
    parameter logic [7:0] HDR0              = DEFAULT_HDR0,
    parameter logic [7:0] HDR1              = DEFAULT_HDR1,
    localparam int        LVL_W             = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      sample_in,
    input  logic             sample_in_valid,
    output logic [7:0]       byte_out,
    output logic             byte_out_valid,
    input  logic             byte_out_ready,
    output logic             frame_active,
    output logic             overflow,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int              SC_W        = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
    localparam logic [SC_W-1:0] LAST_SAMPLE = SC_W'(SAMPLES_PER_FRAME - 1);
    localparam logic [LVL_W-1:0] FRAME_LEVEL = LVL_W'(SAMPLES_PER_FRAME);

    frame_state_t          state;
    frame_state_t          next_state;
    logic [BYTE_IDX_W-1:0] bi;
    logic [SC_W-1:0]       sc;
    logic [7:0]            csum;
    logic [7:0]            seq;

    logic [31:0]           fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  push_ok;
    logic                  xfer;
    logic                  last_byte;
    logic                  last_sample;
    logic [LVL_W-1:0]      level_after;

    assign xfer        = byte_out_valid && byte_out_ready;
    assign last_byte   = (bi == LAST_BYTE_IDX);
    assign last_sample = (sc == LAST_SAMPLE);
    assign push_ok     = sample_in_valid && !fifo_full;
    assign fifo_pop    = (state == ST_DATA) && xfer && last_byte && !fifo_empty;

    // Occupancy after this cycle's update; no pop can happen in CSUM, so only the push counts.
    assign level_after = fifo_level + {{(LVL_W-1){1'b0}}, push_ok};

    send_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_in_valid),
        .pop   (fifo_pop),
        .din   (sample_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Sticky drop flag: set on any sample that arrives while the FIFO is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (sample_in_valid && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a frame starts only once a whole frame of samples is buffered.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (fifo_level >= FRAME_LEVEL) next_state = ST_HDR0;
            ST_HDR0: if (xfer) next_state = ST_HDR1;
            ST_HDR1: if (xfer) next_state = ST_SEQ;
            ST_SEQ:  if (xfer) next_state = ST_DATA;
            ST_DATA: if (xfer && last_byte && last_sample) next_state = ST_CSUM;
            ST_CSUM: begin
                if (xfer) begin
                    next_state = (level_after >= FRAME_LEVEL) ? ST_HDR0 : ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode from registered state only, so ready never reaches byte_out.
    always_comb begin
        byte_out       = 8'h00;
        byte_out_valid = 1'b0;
        frame_active   = 1'b0;
        case (state)
            ST_HDR0: begin
                byte_out       = HDR0;
                byte_out_valid = 1'b1;
                frame_active   = 1'b1;
            end
            ST_HDR1: begin
                byte_out       = HDR1;
                byte_out_valid = 1'b1;
                frame_active   = 1'b1;
            end
            ST_SEQ: begin
                byte_out       = seq;
                byte_out_valid = 1'b1;
                frame_active   = 1'b1;
            end
            ST_DATA: begin
                byte_out       = sample_byte(fifo_dout, bi);
                byte_out_valid = 1'b1;
                frame_active   = 1'b1;
            end
            ST_CSUM: begin
                byte_out       = csum;
                byte_out_valid = 1'b1;
                frame_active   = 1'b1;
            end
            default: begin
                byte_out       = 8'h00;
                byte_out_valid = 1'b0;
                frame_active   = 1'b0;
            end
        endcase
    end

    // Byte/sample counters, running checksum and frame sequence number.
    always_ff @(posedge clk) begin
        if (rst) begin
            bi   <= '0;
            sc   <= '0;
            csum <= 8'h00;
            seq  <= 8'h00;
        end else if (xfer) begin
            case (state)
                ST_HDR1: csum <= 8'h00;
                ST_SEQ:  csum <= csum ^ byte_out;
                ST_DATA: begin
                    csum <= csum ^ byte_out;
                    bi   <= bi + BYTE_IDX_W'(1);
                    if (last_byte) begin
                        sc <= last_sample ? '0 : sc + SC_W'(1);
                    end
                end
                ST_CSUM: seq <= seq + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signal_send_framer.sv
// Scoreboard bench for signal_send_framer: stimulus queues expected frame
// bytes and point checks; one monitor process compares on every byte
// transfer and services the queued checks on the falling clock edge.
module tb_signal_send_framer;

    localparam int N1 = 8;
    localparam int D1 = 16;
    localparam int N2 = 2;
    localparam int D2 = 4;

    localparam int K_CLR    = 0;
    localparam int K_FAIL   = 1;
    localparam int K_VALID  = 2;
    localparam int K_BYTE   = 3;
    localparam int K_LEVEL  = 4;
    localparam int K_OVF    = 5;
    localparam int K_ACTIVE = 6;
    localparam int K_ACTCNT = 7;
    localparam int K_GAPCNT = 8;
    localparam int K_Q1LEFT = 9;
    localparam int K_Q2LEFT = 10;
    localparam int K_VALID2 = 11;
    localparam int K_LEVEL2 = 12;

    typedef logic [7:0] byte_t;

    typedef struct {
        int    kind;
        string name;
        int    exp_val;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sample_in;
    logic        sample_in_valid;
    logic [7:0]  byte_out;
    logic        byte_out_valid;
    logic        byte_out_ready;
    logic        frame_active;
    logic        overflow;
    logic [4:0]  fifo_level;

    logic [31:0] sample_in_2;
    logic        sample_in_valid_2;
    logic [7:0]  byte_out_2;
    logic        byte_out_valid_2;
    logic        byte_out_ready_2;
    logic        frame_active_2;
    logic        overflow_2;
    logic [2:0]  fifo_level_2;

    logic        ready_force;
    logic        bp_en;
    logic        ready_rand = 1'b0;
    logic        gap_en;

    byte_t q1 [$];
    byte_t q2 [$];
    req_t  reqs [$];
    int    errors = 0;
    int    checks = 0;
    int    active_cnt = 0;
    int    gap_cnt = 0;

    byte_t n2_frame [12] = '{8'hA5, 8'h5A, 8'h00, 8'h11, 8'h22, 8'h33,
                             8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};

    assign byte_out_ready = bp_en ? ready_rand : ready_force;

    // Free-running clock.
    always #5 clk = ~clk;

    // Pseudo-random ready pattern used while backpressure is enabled.
    always begin
        @(posedge clk);
        #1;
        ready_rand = 1'($urandom_range(0, 1));
    end

    signal_send_framer #(
        .SAMPLES_PER_FRAME (N1),
        .FIFO_DEPTH        (D1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .byte_out        (byte_out),
        .byte_out_valid  (byte_out_valid),
        .byte_out_ready  (byte_out_ready),
        .frame_active    (frame_active),
        .overflow        (overflow),
        .fifo_level      (fifo_level)
    );

    signal_send_framer #(
        .SAMPLES_PER_FRAME (N2),
        .FIFO_DEPTH        (D2)
    ) dut2 (
        .clk             (clk),
        .rst             (rst),
        .sample_in       (sample_in_2),
        .sample_in_valid (sample_in_valid_2),
        .byte_out        (byte_out_2),
        .byte_out_valid  (byte_out_valid_2),
        .byte_out_ready  (byte_out_ready_2),
        .frame_active    (frame_active_2),
        .overflow        (overflow_2),
        .fifo_level      (fifo_level_2)
    );

    function automatic int observe(input int kind);
        case (kind)
            K_VALID:  return int'(byte_out_valid);
            K_BYTE:   return int'(byte_out);
            K_LEVEL:  return int'(fifo_level);
            K_OVF:    return int'(overflow);
            K_ACTIVE: return int'(frame_active);
            K_ACTCNT: return active_cnt;
            K_GAPCNT: return gap_cnt;
            K_Q1LEFT: return q1.size();
            K_Q2LEFT: return q2.size();
            K_VALID2: return int'(byte_out_valid_2);
            K_LEVEL2: return int'(fifo_level_2);
            default:  return -1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp_val);
        checks++;
        if (got !== exp_val) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp_val, $time);
        end
    endtask

    // Monitor: services queued point checks, then scores any byte transfer.
    logic  prev_stall = 1'b0;
    byte_t prev_byte = 8'h00;
    req_t  cur_req;
    always @(negedge clk) begin
        while (reqs.size() > 0) begin
            cur_req = reqs.pop_front();
            if (cur_req.kind == K_CLR) begin
                active_cnt = 0;
                gap_cnt    = 0;
            end else begin
                checkOutput(cur_req.name, observe(cur_req.kind), cur_req.exp_val);
            end
        end
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_stable", int'({byte_out_valid, byte_out}), int'({1'b1, prev_byte}));
            end
            if (byte_out_valid && byte_out_ready) begin
                if (q1.size() == 0) begin
                    checkOutput("dut_extra_byte", int'(byte_out), -1);
                end else begin
                    checkOutput("dut_byte", int'(byte_out), int'(q1.pop_front()));
                end
            end
            prev_stall = byte_out_valid && !byte_out_ready;
            prev_byte  = byte_out;
            if (frame_active) active_cnt++;
            if (gap_en && q1.size() > 0 && !frame_active) gap_cnt++;
            if (byte_out_valid_2 && byte_out_ready_2) begin
                if (q2.size() == 0) begin
                    checkOutput("dut2_extra_byte", int'(byte_out_2), -1);
                end else begin
                    checkOutput("dut2_byte", int'(byte_out_2), int'(q2.pop_front()));
                end
            end
        end
    end

    task automatic request(input int kind, input string name, input int exp_val);
        req_t r;
        r.kind    = kind;
        r.name    = name;
        r.exp_val = exp_val;
        reqs.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input logic [31:0] value);
        if (which == 1) begin
            sample_in       = value;
            sample_in_valid = 1'b1;
        end else begin
            sample_in_2       = value;
            sample_in_valid_2 = 1'b1;
        end
        tick();
        sample_in_valid   = 1'b0;
        sample_in_valid_2 = 1'b0;
    endtask

    task automatic expect_frame(input byte_t sq, input logic [31:0] s [N1]);
        byte_t cs;
        byte_t b;
        cs = sq;
        q1.push_back(8'hA5);
        q1.push_back(8'h5A);
        q1.push_back(sq);
        for (int k = 0; k < N1; k++) begin
            for (int j = 3; j >= 0; j--) begin
                b = s[k][8*j +: 8];
                q1.push_back(b);
                cs = cs ^ b;
            end
        end
        q1.push_back(cs);
    endtask

    task automatic wait_idle(input int which, input int max_cycles, input string name);
        for (int n = 0; n < max_cycles; n++) begin
            if (which == 1 && q1.size() == 0 && !frame_active) return;
            if (which == 2 && q2.size() == 0 && !frame_active_2) return;
            tick();
        end
        request(K_FAIL, name, 0);
    endtask

    task automatic wait_room();
        int n;
        n = 0;
        while (fifo_level >= 5'd12 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) request(K_FAIL, "stream_room_timeout", 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        logic [31:0] s [N1];
        int          n;

        rst               = 1'b1;
        sample_in         = '0;
        sample_in_valid   = 1'b0;
        sample_in_2       = '0;
        sample_in_valid_2 = 1'b0;
        byte_out_ready_2  = 1'b1;
        ready_force       = 1'b1;
        bp_en             = 1'b0;
        gap_en            = 1'b0;
        repeat (2) tick();

        $display("[TB] reset state");
        request(K_VALID,  "reset_valid", 0);
        request(K_BYTE,   "reset_byte", 0);
        request(K_LEVEL,  "reset_level", 0);
        request(K_OVF,    "reset_overflow", 0);
        request(K_ACTIVE, "reset_active", 0);
        request(K_VALID2, "reset_valid2", 0);
        rst = 1'b0;

        $display("[TB] default frame");
        request(K_CLR, "", 0);
        for (int k = 0; k < N1; k++) s[k] = 32'(k + 1);
        expect_frame(8'h00, s);
        for (int k = 0; k < N1; k++) applyStimulus(1, s[k]);
        request(K_LEVEL, "start_level", 8);
        request(K_VALID, "start_still_idle", 0);
        tick();
        request(K_VALID,  "start_valid", 1);
        request(K_BYTE,   "start_hdr0", 8'hA5);
        request(K_ACTIVE, "start_active", 1);
        wait_idle(1, 200, "t1_drain_timeout");
        request(K_ACTCNT, "t1_active_cycles", 36);
        request(K_LEVEL,  "t1_end_level", 0);
        request(K_Q1LEFT, "t1_bytes_left", 0);

        $display("[TB] N=2 frame");
        foreach (n2_frame[i]) q2.push_back(n2_frame[i]);
        applyStimulus(2, 32'h11223344);
        applyStimulus(2, 32'h55667788);
        wait_idle(2, 100, "t2_drain_timeout");
        request(K_Q2LEFT, "t2_bytes_left", 0);
        request(K_LEVEL2, "t2_end_level", 0);

        $display("[TB] backpressure");
        bp_en = 1'b1;
        expect_frame(8'h01, s);
        for (int k = 0; k < N1; k++) applyStimulus(1, s[k]);
        wait_idle(1, 1000, "t3_drain_timeout");
        bp_en = 1'b0;
        request(K_Q1LEFT, "t3_bytes_left", 0);

        $display("[TB] overflow");
        pulse_reset();
        ready_force = 1'b0;
        for (int k = 0; k < N1; k++) s[k] = 32'h100 + 32'(k);
        expect_frame(8'h00, s);
        for (int k = 0; k < N1; k++) s[k] = 32'h108 + 32'(k);
        expect_frame(8'h01, s);
        for (int k = 0; k < 16; k++) applyStimulus(1, 32'h100 + 32'(k));
        request(K_LEVEL, "t4_level_16", 16);
        request(K_OVF,   "t4_no_overflow_yet", 0);
        applyStimulus(1, 32'h110);
        request(K_LEVEL, "t4_level_after_drop", 16);
        request(K_OVF,   "t4_overflow_set", 1);
        ready_force = 1'b1;
        wait_idle(1, 300, "t4_drain_timeout");
        request(K_LEVEL,  "t4_end_level", 0);
        request(K_OVF,    "t4_overflow_sticky", 1);
        request(K_Q1LEFT, "t4_bytes_left", 0);
        tick();

        $display("[TB] sequence wrap, back-to-back");
        pulse_reset();
        request(K_OVF, "t5_overflow_cleared", 0);
        request(K_CLR, "", 0);
        for (int i = 0; i < 257 * N1; i++) begin
            if (i % N1 == 0) begin
                for (int k = 0; k < N1; k++) s[k] = 32'hC000_0000 + 32'(i + k);
                expect_frame(8'(i / N1), s);
            end
            if (i == N1 + 2) gap_en = 1'b1;
            wait_room();
            applyStimulus(1, 32'hC000_0000 + 32'(i));
        end
        wait_idle(1, 2000, "t5_drain_timeout");
        gap_en = 1'b0;
        request(K_GAPCNT, "t5_idle_gap_cycles", 0);
        request(K_OVF,    "t5_no_overflow", 0);
        request(K_Q1LEFT, "t5_bytes_left", 0);
        tick();

        $display("[TB] reset mid-frame");
        pulse_reset();
        for (int k = 0; k < N1; k++) s[k] = 32'h2000_0000 + 32'(k);
        expect_frame(8'h00, s);
        for (int k = 0; k < N1; k++) applyStimulus(1, s[k]);
        n = 0;
        while (q1.size() > 20 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) request(K_FAIL, "t6_reach_sample3_timeout", 0);
        rst = 1'b1;
        q1.delete();
        tick();
        request(K_VALID,  "t6_valid_after_rst", 0);
        request(K_LEVEL,  "t6_level_after_rst", 0);
        request(K_ACTIVE, "t6_active_after_rst", 0);
        rst = 1'b0;
        request(K_CLR, "", 0);
        for (int k = 0; k < N1; k++) s[k] = 32'h3000_0000 + 32'(k * 3);
        expect_frame(8'h00, s);
        for (int k = 0; k < N1; k++) applyStimulus(1, s[k]);
        wait_idle(1, 200, "t6_drain_timeout");
        request(K_ACTCNT, "t6_active_cycles", 36);
        request(K_Q1LEFT, "t6_bytes_left", 0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signal_send_framer.md
# signal_send_framer

Downstream stage of the modulator: it consumes the 32-bit modulated sample stream (`Signal_Send` / `Signal_Send_valid`) and buffers it in a small synchronous FIFO. It emits fixed-length byte frames over a ready/valid byte interface toward the transmit link (UART/DAC bridge). Each frame carries a header, a sequence number, N big-endian samples and an XOR checksum. The upstream side has no backpressure, so overruns are dropped and flagged.

## Interface
- `SAMPLES_PER_FRAME`, 8: samples per frame (N ≥ 1)
- `FIFO_DEPTH`, 16: sample FIFO depth; power of 2, ≥ `SAMPLES_PER_FRAME`
- `HDR0`, 8'hA5: first header byte
- `HDR1`, 8'h5A: second header byte

- `clk` in 1: system clock, single domain
- `rst` in 1: synchronous, active-high reset
- `sample_in` in 32: modulated sample (from `Signal_Send`)
- `sample_in_valid` in 1: sample qualifier (from `Signal_Send_valid`)
- `byte_out` out 8: frame byte
- `byte_out_valid` out 1: byte valid
- `byte_out_ready` in 1: sink accepts the byte
- `frame_active` out 1: high from the HDR0 state through the CSUM state inclusive
- `overflow` out 1: sticky; a sample was dropped
- `fifo_level` out $clog2(FIFO_DEPTH)+1: registered FIFO occupancy

## Operation
- **Write:** push `sample_in` when `sample_in_valid` && level < `FIFO_DEPTH`.
  - When `sample_in_valid` && level == `FIFO_DEPTH`, the sample is dropped and `overflow` is set.
  - `overflow` clears only on `rst`.
  - Full is judged on the registered level. A pop in the same cycle does not make room.
- **Handshake:** a byte transfers on `byte_out_valid && byte_out_ready`. Once valid is asserted, `byte_out` and valid stay stable until the byte transfers.
- **FSM states:** IDLE, HDR0, HDR1, SEQ, DATA, CSUM.
  - IDLE → HDR0 when level ≥ `SAMPLES_PER_FRAME`. A frame therefore starts only when fully buffered, and DATA never starves.
  - HDR0 → HDR1 → SEQ → DATA, each on transfer.
  - DATA: the byte index `bi` (0..3) and the sample counter `sc` (0..N-1) advance on each transfer.
  - The bytes of a sample go out MSB first: `sample[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
  - The FIFO pops on transfer of byte `bi`=3.
  - After byte 3 of sample N-1, go to CSUM.
  - CSUM → HDR0 on transfer if level (after that cycle's update) ≥ N, else → IDLE.
- **Output bytes:** IDLE drives `byte_out`=0 with valid low. Every other state drives valid high.
- **Checksum:** `csum` is cleared when HDR1 transfers. On each SEQ and DATA transfer, `csum ^= byte_out`. CSUM emits `csum`.
- **Sequence number:** `seq` (8-bit) increments when CSUM transfers and wraps 255 → 0.
- **Frame length:** 4 + 4N bytes (36 at the default).
- **Simultaneous push and pop:** level unchanged. Push only: +1. Pop only: −1.

## Timing
- **Reset values:** `byte_out`=0, `byte_out_valid`=0, `frame_active`=0, `overflow`=0, `fifo_level`=0, `seq`=0, state IDLE, FIFO pointers 0.
- **Write latency:** `fifo_level` reflects a push one cycle after the write edge.
- **Frame start latency:** level reaches N at edge t; the FSM leaves IDLE at edge t+1; `byte_out_valid`=1 with `HDR0` from t+1. All outputs are registered, with no combinational path from `byte_out_ready` to `byte_out`.
- **Throughput:** one byte per cycle with `ready` held high. Frames go back-to-back with no idle cycle when data is available.
- **Reset mid-frame:** the frame is abandoned, the FIFO is flushed, `seq` returns to 0, and no partial CSUM is emitted.
- `ready` low in any state: the FSM holds and the FIFO keeps accepting input until full.

## Structure
- Shared package (`framer_pkg`):
  - state enumeration (6 states, 3-bit encoding)
  - default `HDR0` and `HDR1` constants
  - byte-index width constant
- One sub-module, `send_fifo`: synchronous FIFO with parameters `WIDTH`=32 and `DEPTH`. It provides registered level, `full`, `empty`, and a first-word-fall-through read (`dout` valid whenever not empty).
- The FSM, counters, checksum and output register stay in `signal_send_framer`.

## Test plan
1. **Default frame:** `rst` 2 cycles, then push 0x00000001..0x00000008 on consecutive cycles, `ready`=1 → `byte_out` = A5 5A 00 00 00 00 01 … 00 00 00 08 08. That is 36 bytes, checksum 0x08; `frame_active` high for exactly 36 cycles.
2. **N=2 override:** push 0x11223344, 0x55667788 → A5 5A 00 11 22 33 44 55 66 77 88 88. Checksum 0x88.
3. **Backpressure:** toggle `ready` pseudo-randomly during scenario 1 → identical byte sequence, with `byte_out` stable while `valid`&&!`ready`.
4. **Overflow:** `ready`=0 and 17 pushes → `fifo_level`=16 and `overflow`=1 after the 17th. With `ready`=1, the first 16 samples are emitted in two frames (seq 00, 01); the 17th sample never appears.
5. **Sequence wrap and back-to-back:** stream continuously for 257 frames → seq runs 00..FF then 00, with no idle cycle between frames.
6. **Reset mid-frame:** assert `rst` during DATA at sample 3 → next cycle `valid`=0 and level=0. After 8 new pushes, the frame starts with seq 00.
